// File: rtl/ascii2score_converter.sv
// Turns a keyboard/UART character stream into a 0..99 score: up to two digits,
// backspace and escape editing, commit on carriage return, sticky error on bad input.
module ascii2score_converter (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] ascii_in,
  input  logic       ascii_valid,
  output logic [6:0] score,
  output logic       score_valid,
  output logic       error,
  output logic [1:0] digits
);

  // state | meaning
  // IDLE  | no digits held
  // ACCUM | one or two digits held (cnt)
  // ERR   | bad char or third digit; waits for CR/ESC
  localparam logic [6:0] TERM_CHAR = 7'h0D;
  localparam logic [6:0] BKSP_CHAR = 7'h08;
  localparam logic [6:0] ESC_CHAR  = 7'h1B;

  typedef enum logic [1:0] {IDLE, ACCUM, ERR} state_t;

  state_t     state;
  logic [3:0] dig_hi;
  logic [3:0] dig_lo;
  logic [1:0] cnt;

  logic       is_digit;
  logic       is_term;
  logic       is_bksp;
  logic       is_esc;
  logic [3:0] digit_val;
  logic [6:0] hi_x10;
  logic [6:0] two_digit;

  assign is_digit  = (ascii_in >= 7'h30) && (ascii_in <= 7'h39);
  assign is_term   = (ascii_in == TERM_CHAR);
  assign is_bksp   = (ascii_in == BKSP_CHAR);
  assign is_esc    = (ascii_in == ESC_CHAR);
  // '0'..'9' are 0x30..0x39, so the low nibble equals ascii_in - 0x30
  assign digit_val = ascii_in[3:0];
  assign hi_x10    = ({3'b000, dig_hi} << 3) + ({3'b000, dig_hi} << 1);
  assign two_digit = hi_x10 + {3'b000, dig_lo};
  assign digits    = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dig_hi      <= 4'd0;
      dig_lo      <= 4'd0;
      cnt         <= 2'd0;
      score       <= 7'd0;
      score_valid <= 1'b0;
      error       <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      if (ascii_valid) begin
        case (state)
          IDLE: begin
            if (is_digit) begin
              dig_hi <= digit_val;
              cnt    <= 2'd1;
              state  <= ACCUM;
            end else if (!(is_term || is_bksp || is_esc)) begin
              state <= ERR;
              error <= 1'b1;
            end
          end
          ACCUM: begin
            if (is_digit) begin
              if (cnt == 2'd1) begin
                dig_lo <= digit_val;
                cnt    <= 2'd2;
              end else begin
                cnt   <= 2'd0;
                state <= ERR;
                error <= 1'b1;
              end
            end else if (is_esc) begin
              cnt   <= 2'd0;
              state <= IDLE;
            end else if (is_bksp) begin
              if (cnt == 2'd1) begin
                cnt   <= 2'd0;
                state <= IDLE;
              end else begin
                cnt <= 2'd1;
              end
            end else if (is_term) begin
              score       <= (cnt == 2'd1) ? {3'b000, dig_hi} : two_digit;
              score_valid <= 1'b1;
              cnt         <= 2'd0;
              state       <= IDLE;
            end else begin
              cnt   <= 2'd0;
              state <= ERR;
              error <= 1'b1;
            end
          end
          ERR: begin
            cnt <= 2'd0;
            if (is_term || is_esc) begin
              state <= IDLE;
              error <= 1'b0;
            end
          end
          default: begin
            cnt   <= 2'd0;
            error <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascii2score_converter.sv
// Scoreboard bench for ascii2score_converter: each sent character queues its
// hand-computed expected outputs, a monitor checks them one cycle later.
module tb_ascii2score_converter;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] ascii_in;
  logic       ascii_valid;
  logic [6:0] score;
  logic       score_valid;
  logic       error;
  logic [1:0] digits;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] d;
    logic       e;
    logic [6:0] s;
    logic       v;
  } exp_t;

  exp_t exp_q[$];

  ascii2score_converter dut (
    .clk         (clk),
    .rst         (rst),
    .ascii_in    (ascii_in),
    .ascii_valid (ascii_valid),
    .score       (score),
    .score_valid (score_valid),
    .error       (error),
    .digits      (digits)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: one cycle after an accepted character, pop and compare.
  always @(posedge clk) begin
    logic fire;
    exp_t e;
    fire = ascii_valid && !rst;
    #1;
    if (fire) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("digits", int'(digits), int'(e.d));
        check("error", int'(error), int'(e.e));
        check("score", int'(score), int'(e.s));
        check("score_valid", int'(score_valid), int'(e.v));
      end
    end else if (score_valid) begin
      check("spurious_score_valid", 1, 0);
    end
  end

  task automatic send(input logic [6:0] ch, input logic [1:0] d, input logic e,
                      input logic [6:0] s, input logic v);
    exp_t x;
    x.d = d; x.e = e; x.s = s; x.v = v;
    exp_q.push_back(x);
    @(negedge clk);
    ascii_in    = ch;
    ascii_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    ascii_valid = 1'b0;
    ascii_in    = 7'h00;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset(input logic v, input logic [6:0] ch);
    @(negedge clk);
    rst         = 1'b1;
    ascii_valid = v;
    ascii_in    = ch;
    @(negedge clk);
    check("rst_score", int'(score), 0);
    check("rst_score_valid", int'(score_valid), 0);
    check("rst_error", int'(error), 0);
    check("rst_digits", int'(digits), 0);
    rst         = 1'b0;
    ascii_valid = 1'b0;
  endtask

  localparam logic [6:0] CR  = 7'h0D;
  localparam logic [6:0] BS  = 7'h08;
  localparam logic [6:0] ESC = 7'h1B;

  initial begin
    rst = 1'b1; ascii_valid = 1'b0; ascii_in = 7'h00;
    do_reset(1'b0, 7'h00);

    // "4","2",CR back-to-back
    send("4", 2'd1, 1'b0, 7'd0, 1'b0);
    send("2", 2'd2, 1'b0, 7'd0, 1'b0);
    send(CR,  2'd0, 1'b0, 7'd42, 1'b1);
    idle(2);

    // "9","8",BS,"5",CR then "7",CR
    send("9", 2'd1, 1'b0, 7'd42, 1'b0);
    send("8", 2'd2, 1'b0, 7'd42, 1'b0);
    send(BS,  2'd1, 1'b0, 7'd42, 1'b0);
    send("5", 2'd2, 1'b0, 7'd42, 1'b0);
    send(CR,  2'd0, 1'b0, 7'd95, 1'b1);
    send("7", 2'd1, 1'b0, 7'd95, 1'b0);
    send(CR,  2'd0, 1'b0, 7'd7, 1'b1);
    idle(1);

    // overflow on third digit, sticky error, CR clears without commit
    send("1", 2'd1, 1'b0, 7'd7, 1'b0);
    send("2", 2'd2, 1'b0, 7'd7, 1'b0);
    send("3", 2'd0, 1'b1, 7'd7, 1'b0);
    send("5", 2'd0, 1'b1, 7'd7, 1'b0);
    send(CR,  2'd0, 1'b0, 7'd7, 1'b0);

    // controls ignored in IDLE, bad char errors, ESC recovers
    send(CR,  2'd0, 1'b0, 7'd7, 1'b0);
    send(BS,  2'd0, 1'b0, 7'd7, 1'b0);
    send("A", 2'd0, 1'b1, 7'd7, 1'b0);
    send(ESC, 2'd0, 1'b0, 7'd7, 1'b0);

    // held state across gaps, BS down to IDLE, bad char in ACCUM
    send("3", 2'd1, 1'b0, 7'd7, 1'b0);
    idle(3);
    send(BS,  2'd0, 1'b0, 7'd7, 1'b0);
    send("8", 2'd1, 1'b0, 7'd7, 1'b0);
    send("x", 2'd0, 1'b1, 7'd7, 1'b0);
    send(ESC, 2'd0, 1'b0, 7'd7, 1'b0);

    // max value and leading zero
    send("9", 2'd1, 1'b0, 7'd7, 1'b0);
    send("9", 2'd2, 1'b0, 7'd7, 1'b0);
    send(CR,  2'd0, 1'b0, 7'd99, 1'b1);
    send("0", 2'd1, 1'b0, 7'd99, 1'b0);
    send("5", 2'd2, 1'b0, 7'd99, 1'b0);
    send(CR,  2'd0, 1'b0, 7'd5, 1'b1);

    // reset mid-entry wins over a valid character
    send("6", 2'd1, 1'b0, 7'd5, 1'b0);
    do_reset(1'b1, "3");
    send("0", 2'd1, 1'b0, 7'd0, 1'b0);
    send(CR,  2'd0, 1'b0, 7'd0, 1'b1);

    // ESC aborts the entry; the following CR in IDLE does nothing
    send("4", 2'd1, 1'b0, 7'd0, 1'b0);
    send("2", 2'd2, 1'b0, 7'd0, 1'b0);
    send(CR,  2'd0, 1'b0, 7'd42, 1'b1);
    send("5", 2'd1, 1'b0, 7'd42, 1'b0);
    send(ESC, 2'd0, 1'b0, 7'd42, 1'b0);
    send(CR,  2'd0, 1'b0, 7'd42, 1'b0);
    idle(3);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascii2score_converter.md
# ascii2score_converter

Converts a stream of 7-bit ASCII characters (from the keyboard/UART receive path) into a binary score, the inverse of the score-to-ASCII display conversion. It accepts up to two decimal digits, supports backspace and escape, and commits the value on a carriage return. It rejects invalid characters and a third digit with a sticky error until the entry is terminated. It sits between the character receiver and the game-logic score register.

## Interface
- TERM_CHAR, 7'h0D, commit character (carriage return)
- BKSP_CHAR, 7'h08, backspace character
- ESC_CHAR, 7'h1B, abort character
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- ascii_in  input  7  ASCII character code
- ascii_valid  input  1  ascii_in valid this cycle; one character per cycle, back-to-back allowed
- score  output  7  last committed value, 0..99; held between commits
- score_valid  output  1  one-cycle pulse when score is updated
- error  output  1  high while in ERR state
- digits  output  2  number of digits currently held (0..2), for echo/display

## Operation
- State machine: IDLE (no digits), ACCUM (1 or 2 digits held), ERR.
- Internal registers: dig_hi[3:0], dig_lo[3:0], cnt[1:0] (drives digits), state.
- Characters are processed only when ascii_valid=1. With ascii_valid=0, all state holds.
- A digit is any ascii_in in 7'h30..7'h39. Its value is ascii_in - 7'h30.
- IDLE:
  - A digit stores dig_hi, sets cnt=1, and moves to ACCUM.
  - TERM_CHAR, BKSP_CHAR and ESC_CHAR are ignored: no pulse and no state change.
  - Any other character moves to ERR.
- ACCUM with cnt=1:
  - A digit stores dig_lo and sets cnt=2.
  - BKSP_CHAR sets cnt=0 and moves to IDLE.
  - TERM_CHAR commits score=dig_hi.
- ACCUM with cnt=2:
  - A digit causes overflow and moves to ERR.
  - BKSP_CHAR sets cnt=1 and keeps dig_hi.
  - TERM_CHAR commits score=dig_hi*10+dig_lo.
- Commit: write score, pulse score_valid, set cnt=0, move to IDLE.
- ESC_CHAR in ACCUM or ERR sets cnt=0 and moves to IDLE, with no pulse.
- Any non-digit, non-control character in ACCUM moves to ERR.
- ERR:
  - error=1, and cnt is forced to 0.
  - All characters are discarded except TERM_CHAR and ESC_CHAR, which both return to IDLE with no score_valid.
  - score keeps its previous value.
- Arithmetic: dig_hi*10 is computed as (dig_hi<<3)+(dig_hi<<1) in 7 bits. The result is at most 99, so there is no wrap.
- Leading zeros are legal: "0","5",CR gives 5, and "0",CR gives 0.
- Reset values: score=0, score_valid=0, error=0, digits=0, state=IDLE, dig_hi=dig_lo=0.

## Timing
- All outputs are registered.
- A character sampled at edge N is reflected on digits, error, score and score_valid after edge N, i.e. during cycle N+1. Latency is 1 clock.
- score_valid is high for exactly one cycle per commit. score changes in the same cycle score_valid rises.
- Back-to-back characters on consecutive cycles are all processed. A digit immediately followed by TERM_CHAR commits the two-digit or one-digit value correctly.
- rst has priority over ascii_valid in the same cycle.
- rst mid-entry discards the held digits and clears score to 0, with no score_valid.
- No backpressure. The block is always ready.

## Test plan
- After reset, send "4","2",CR on consecutive cycles. Required: score=42 with score_valid high for 1 cycle, one cycle after CR; digits goes 1,2,0.
- Send "9","8",BS,"5",CR. Required: score=95 and one pulse. Then send "7",CR. Required: score=7.
- Send "1","2","3". Required: error=1 one cycle after "3". Then send "5". Required: still error. Then send CR. Required: error=0, no score_valid, score unchanged at its prior value.
- In IDLE send CR, then BS. Required: no pulse and no state change. Then send "A". Required: error=1. Then send ESC. Required: error=0, IDLE.
- Send "6", then assert rst with ascii_valid=1 and ascii_in="3". Required: all outputs return to reset values the next cycle. Then send "0",CR. Required: score=0 with one pulse.
- Send "5",ESC,CR. Required: no score_valid, and score retains its previous value.
